// File: rtl/icache_axi_responder.sv
// AXI read-only responder serving instruction-cache line fills from a local word memory.
// A single outstanding burst: accept AR, wait a fixed latency, then stream R beats.
module icache_axi_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     ar_valid,
    output logic                     ar_ready,
    input  logic [ID_WIDTH-1:0]      ar_id,
    input  logic [ADDR_WIDTH-1:0]    ar_addr,
    input  logic [7:0]               ar_len,
    input  logic [2:0]               ar_size,
    input  logic [1:0]               ar_burst,

    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [ID_WIDTH-1:0]      r_id,
    output logic [DATA_WIDTH-1:0]    r_data,
    output logic [1:0]               r_resp,
    output logic                     r_last,

    input  logic                     mem_we,
    input  logic [$clog2(DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]    mem_wdata
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         OFF_W    = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
    localparam logic [3:0] LAT      = 4'(LATENCY);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              lat_q, lat_d;
    logic [7:0]              beat_q, beat_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    slverr_q, slverr_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   step;
    logic [ADDR_WIDTH-1:0]   wrap_mask;
    logic [ADDR_WIDTH-1:0]   addr_incr;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   mem_rd;
    logic                    ar_bad_wrap;
    logic                    ar_rsvd;
    logic                    ar_fire;
    logic [1:0]              resp;

    // Preload/update port; deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        addr_incr = addr_q + step;
        case (burst_q)
            BURST_FIXED: addr_next = addr_q;
            BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_incr & wrap_mask);
            default:     addr_next = addr_incr;
        endcase
        word_idx = addr_q >> OFF_W;
        in_range = (word_idx >> IDX_W) == '0;
        mem_rd   = mem_q[word_idx[IDX_W-1:0]];
    end

    assign ar_bad_wrap = (ar_burst == BURST_WRAP) &&
                         !((ar_len == 8'd1) || (ar_len == 8'd3) ||
                           (ar_len == 8'd7) || (ar_len == 8'd15));
    assign ar_rsvd     = (ar_burst == BURST_RSVD);
    assign ar_fire     = ar_valid && ar_ready;

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        slverr_d = slverr_q;
        ar_ready = 1'b0;
        r_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ar_ready = 1'b1;
                if (ar_fire) begin
                    id_d     = ar_id;
                    addr_d   = ar_addr;
                    len_d    = ar_len;
                    size_d   = ar_size;
                    // Illegal burst encodings are walked as INCR; their beats are all SLVERR.
                    burst_d  = (ar_rsvd || ar_bad_wrap) ? BURST_INCR : ar_burst;
                    slverr_d = ar_rsvd || ar_bad_wrap || (ar_size > MAX_SIZE);
                    beat_d   = 8'd0;
                    if (LATENCY == 0) begin
                        state_d = S_BURST;
                    end else begin
                        lat_d   = LAT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    if (beat_q == len_q) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lat_q    <= 4'd0;
            beat_q   <= 8'd0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'b00;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            slverr_q <= slverr_d;
        end
    end

    // SLVERR outranks DECERR; every R field reads zero outside a beat.
    always_comb begin
        resp = 2'b00;
        if (r_valid) begin
            if (slverr_q) begin
                resp = 2'b10;
            end else if (!in_range) begin
                resp = 2'b11;
            end
        end
    end

    assign r_resp = resp;
    assign r_id   = r_valid ? id_q : '0;
    assign r_last = r_valid && (beat_q == len_q);
    assign r_data = (r_valid && (resp == 2'b00)) ? mem_rd : '0;

endmodule
